// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_BITS data bits (LSB first), optional odd/even
// parity, 1..2 stop bits, one-deep holding register for gapless back-to-back frames.
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_,
    input  logic                 rst_n,
    input  logic                 clken,
    input  logic [DATA_BITS-1:0] datain,
    input  logic                 wr_en,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_state,
    output logic                 frame_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_tx_param: illegal DATA_BITS/PARITY/STOP_BITS");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_END = 4'(STOP_BITS);

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic [3:0]             bitpos_q, bitpos_d;
    logic                   tx_q, tx_d;
    logic                   tx_state_q, tx_state_d;
    logic                   load;

    assign tx_ready = ~hold_valid_q;
    assign tx       = tx_q;
    assign tx_state = tx_state_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        bitpos_d     = bitpos_q;
        tx_d         = tx_q;
        tx_state_d   = tx_state_q;
        frame_done   = 1'b0;
        load         = 1'b0;

        if (wr_en && tx_ready) begin
            hold_d       = datain;
            hold_valid_d = 1'b1;
        end

        if (clken) begin
            case (state_q)
                S_IDLE: begin
                    if (hold_valid_q) load = 1'b1;
                end
                S_DATA: begin
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitpos_d = bitpos_q + 4'd1;
                    if (bitpos_q == LAST_BIT) begin
                        bitpos_d = 4'd0;
                        state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    tx_d    = par_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    // bitpos counts stop bits already on the line; reaching
                    // STOP_END means this tick closes the frame.
                    if (bitpos_q == STOP_END) begin
                        frame_done = 1'b1;
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            state_d    = S_IDLE;
                            tx_state_d = 1'b1;
                            bitpos_d   = 4'd0;
                        end
                    end else begin
                        tx_d     = 1'b1;
                        bitpos_d = bitpos_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Start bit and load are shared by IDLE and the STOP end tick.
        if (load) begin
            tx_d         = 1'b0;
            shreg_d      = hold_q;
            par_d        = (PARITY == 1) ? ~(^hold_q) : (^hold_q);
            hold_valid_d = 1'b0;
            bitpos_d     = 4'd0;
            tx_state_d   = 1'b0;
            state_d      = S_DATA;
        end
    end

    always_ff @(posedge clk_ or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            bitpos_q     <= 4'd0;
            tx_q         <= 1'b1;
            tx_state_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            bitpos_q     <= bitpos_d;
            tx_q         <= tx_d;
            tx_state_q   <= tx_state_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7O2) checked tick by
// tick against a frame-bit reference built from the framing rules.
module tb_uart_tx_param;

    localparam int DB[4] = '{8, 8, 8, 7};
    localparam int PB[4] = '{0, 2, 1, 1};
    localparam int SB[4] = '{1, 1, 1, 2};

    logic       clk, rst_n, clken;
    logic [7:0] din;
    logic [3:0] wr_en, ready, txs, st, fd;

    int total = 0, bad = 0;
    int sel = 0, div = 4, cnt = 0, glitch = 0;
    bit lg[$], stl[$], exp_q[$];
    int fdq[$], wq[$];
    bit prev_tick, prev_tx;

    uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk_(clk), .rst_n(rst_n), .clken(clken), .datain(din), .wr_en(wr_en[0]),
        .tx_ready(ready[0]), .tx(txs[0]), .tx_state(st[0]), .frame_done(fd[0]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk_(clk), .rst_n(rst_n), .clken(clken), .datain(din), .wr_en(wr_en[1]),
        .tx_ready(ready[1]), .tx(txs[1]), .tx_state(st[1]), .frame_done(fd[1]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk_(clk), .rst_n(rst_n), .clken(clken), .datain(din), .wr_en(wr_en[2]),
        .tx_ready(ready[2]), .tx(txs[2]), .tx_state(st[2]), .frame_done(fd[2]));
    uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .clk_(clk), .rst_n(rst_n), .clken(clken), .datain(din[6:0]), .wr_en(wr_en[3]),
        .tx_ready(ready[3]), .tx(txs[3]), .tx_state(st[3]), .frame_done(fd[3]));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Baud tick: one pulse every div clocks, changed just after the rising edge.
    initial begin
        clken = 0;
        forever begin
            @(posedge clk); #1;
            if (cnt >= div - 1) begin clken = 1; cnt = 0; end
            else begin clken = 0; cnt++; end
        end
    end

    // Line monitor for the selected instance: logs tx/tx_state after every tick.
    initial begin
        prev_tick = 0; prev_tx = 1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tick = 0; prev_tx = 1;
            end else begin
                if (prev_tick) begin
                    lg.push_back(txs[sel]);
                    stl.push_back(st[sel]);
                end else if (txs[sel] != prev_tx) glitch++;
                if (fd[sel] && clken) fdq.push_back(lg.size());
                if (fd[sel] && !clken) glitch++;
                prev_tick = clken;
                prev_tx   = txs[sel];
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void frame_bits(input int data);
        int ones = 0;
        exp_q.push_back(0);
        for (int i = 0; i < DB[sel]; i++) begin
            exp_q.push_back(((data >> i) & 1) != 0);
            ones += (data >> i) & 1;
        end
        if (PB[sel] == 2) exp_q.push_back((ones % 2) != 0);
        if (PB[sel] == 1) exp_q.push_back((ones % 2) == 0);
        for (int i = 0; i < SB[sel]; i++) exp_q.push_back(1);
    endfunction

    function automatic int first_zero();
        foreach (lg[i]) if (lg[i] == 0) return i;
        return -1;
    endfunction

    task automatic clear_logs();
        lg.delete(); stl.delete(); fdq.delete(); exp_q.delete();
        glitch = 0;
    endtask

    task automatic wr(input int data);
        int n = 0;
        @(posedge clk); #1;
        while (!ready[sel] && n < 2000) begin @(posedge clk); #1; n++; end
        if (n >= 2000) chk("write wait timeout", 0, 1);
        din = 8'(data);
        wr_en[sel] = 1;
        @(posedge clk); #1;
        wr_en = '0;
    endtask

    task automatic wait_done(input string tag, input int n);
        int c = 0;
        while (fdq.size() < n && c < 5000) begin @(negedge clk); c++; end
        if (c >= 5000) chk({tag, " frame_done timeout"}, fdq.size(), n);
        repeat (3 * div + 2) @(negedge clk);
    endtask

    task automatic verify(input string tag, input int n);
        int len, f0, e, fb, z, se;
        len = 1 + DB[sel] + (PB[sel] != 0 ? 1 : 0) + SB[sel];
        f0 = first_zero();
        chk({tag, " start seen"}, (f0 >= 0) ? 1 : 0, 1);
        if (f0 < 0) return;
        e = 0; fb = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            int got = (f0 + i < lg.size()) ? int'(lg[f0 + i]) : 2;
            if (got != int'(exp_q[i])) begin
                e++;
                if (fb < 0) fb = i;
            end
        end
        chk($sformatf("%s bit errors (first bad %0d)", tag, fb), e, 0);
        z = 0;
        for (int j = f0 + exp_q.size(); j < lg.size(); j++) if (lg[j] == 0) z++;
        chk({tag, " idle after frames"}, z, 0);
        se = 0;
        for (int j = f0; j < stl.size(); j++)
            if (int'(stl[j]) != ((j < f0 + len * n) ? 0 : 1)) se++;
        chk({tag, " tx_state errors"}, se, 0);
        chk({tag, " frame_done count"}, fdq.size(), n);
        for (int k = 0; k < n && k < fdq.size(); k++)
            chk($sformatf("%s frame_done tick %0d", tag, k), fdq[k], f0 + len * (k + 1));
        chk({tag, " off-tick changes"}, glitch, 0);
        chk({tag, " tx_ready idle"}, int'(ready[sel]), 1);
        chk({tag, " tx_state idle"}, int'(st[sel]), 1);
    endtask

    task automatic burst(input string tag);
        clear_logs();
        foreach (wq[i]) frame_bits(wq[i]);
        foreach (wq[i]) wr(wq[i]);
        wait_done(tag, wq.size());
        verify(tag, wq.size());
    endtask

    initial begin
        int f0, c;
        rst_n = 0; wr_en = '0; din = '0;
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset tx[%0d]", i), int'(txs[i]), 1);
            chk($sformatf("reset tx_ready[%0d]", i), int'(ready[i]), 1);
            chk($sformatf("reset tx_state[%0d]", i), int'(st[i]), 1);
            chk($sformatf("reset frame_done[%0d]", i), int'(fd[i]), 0);
        end
        rst_n = 1;
        repeat (2) @(posedge clk); #1;

        sel = 0; div = 4; wq = '{8'hA5};       burst("8N1 A5");
        sel = 1;          wq = '{8'h03};       burst("8E1 03");
        sel = 2;          wq = '{8'h03};       burst("8O1 03");
        sel = 3;          wq = '{8'h7F};       burst("7O2 7F");
        sel = 0;          wq = '{8'h55, 8'hAA}; burst("8N1 back-to-back");

        // Overrun: write while the hold is full must be dropped.
        clear_logs();
        frame_bits(8'h11); frame_bits(8'h3C);
        wr(8'h11); wr(8'h3C);
        chk("overrun tx_ready before", int'(ready[0]), 0);
        din = 8'hFF; wr_en[0] = 1;
        @(posedge clk); #1;
        wr_en = '0;
        chk("overrun tx_ready after", int'(ready[0]), 0);
        wait_done("overrun", 2);
        verify("overrun", 2);

        // Reset during data bit 3 with a second byte held.
        clear_logs();
        wr(8'hF0); wr(8'h33);
        c = 0;
        do begin
            @(negedge clk); #2; c++;
            f0 = first_zero();
        end while ((f0 < 0 || lg.size() < f0 + 5) && c < 2000);
        chk("bit3 before reset", int'(txs[0]), 0);
        rst_n = 0; #1;
        chk("midframe reset tx", int'(txs[0]), 1);
        chk("midframe reset tx_ready", int'(ready[0]), 1);
        chk("midframe reset tx_state", int'(st[0]), 1);
        chk("midframe reset frame_done", int'(fd[0]), 0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1;
        wq = '{8'h0F}; burst("after reset 0F");

        // Randomized bursts across all configurations and baud rates.
        for (int t = 0; t < 12; t++) begin
            int n;
            sel = $urandom_range(0, 3);
            div = $urandom_range(1, 5);
            n   = $urandom_range(1, 3);
            repeat (6) @(posedge clk); #1;
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back($urandom_range(0, (1 << DB[sel]) - 1));
            burst($sformatf("rand%0d cfg%0d div%0d", t, sel, div));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter and successor to the fixed 8N1 transmitter. Configurable data width, parity mode and stop-bit count. A one-deep holding register allows back-to-back frames with no idle gap. Bit timing comes from an external baud tick (clken) shared with the existing baud generator. It sits between the processor's output data path and the serial line.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal range 1..2.

Ports:
clk_  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
clken  input  1  baud tick; one-clk_ pulse per bit period; may be held high permanently.
datain  input  DATA_BITS  byte or word to transmit.
wr_en  input  1  write strobe; accepted only when tx_ready=1.
tx_ready  output  1  1 = holding register empty; a write is accepted this cycle.
tx  output  1  serial line; idle high.
tx_state  output  1  1 = FSM idle (no frame on the line); 0 = frame in progress.
frame_done  output  1  one-clk_ pulse on the tick that ends a frame.

Behaviour:
- Reset (async, rst_n=0): tx=1, tx_state=1, tx_ready=1, frame_done=0, hold_valid=0, state=IDLE, bit counter=0.
- Reset mid-frame: line returns to 1 immediately and the partial frame is abandoned. Held data is discarded.
- Holding register:
  - wr_en && tx_ready: capture datain and set hold_valid on the same edge; tx_ready = ~hold_valid.
  - wr_en while tx_ready=0: ignored. No state change and no error flag; the sender must poll tx_ready.
- FSM states: IDLE, DATA, PARITY, STOP. The FSM advances only on cycles with clken=1.
- IDLE: on a clken cycle with hold_valid=1:
  - tx<=0 (start bit); shift register<=hold; hold_valid<=0 (tx_ready=1 next cycle).
  - Parity bit computed from the loaded data: even = XOR of data bits; odd = inverse of that XOR.
  - bitpos<=0; tx_state<=0; go to DATA.
  - A write arriving before the tick still waits for the tick. Start latency is at most one baud period.
- DATA: each tick, tx<=data[bitpos] and bitpos increments. After bit DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
- PARITY: one tick, tx<=parity bit, then go to STOP.
- STOP:
  - Each tick drives tx<=1 and counts stop bits, STOP_BITS ticks in total.
  - The tick after the last stop bit began is the end tick:
    - frame_done=1 for that cycle.
    - If hold_valid=1 on the end tick, the next frame's start bit is driven on that same tick (tx<=0, load, as in IDLE); tx_state stays 0. This gives back-to-back frames with zero idle time.
    - Otherwise go to IDLE and set tx_state<=1; tx remains 1.
- Frame length from start tick to end tick = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS ticks.
- Simultaneous events:
  - wr_en on the same cycle the hold is consumed: ignored, because tx_ready is still 0 that cycle.
  - wr_en during IDLE on a clken cycle with hold empty: captured. The frame starts at the next tick, not the current one.
- clken=1 every cycle is legal; each bit then lasts one clk_.
- tx is a registered output and is glitch-free.
- Illegal parameter values (DATA_BITS outside 5..9, PARITY>2, STOP_BITS outside 1..2) cause an elaboration error via a generate check.
- Bit counter width is 4 bits, enough for DATA_BITS up to 9. No wrap occurs within a frame.

Test Plan:
- 8N1, write 0xA5, clken every 4 clks → tx per tick: 0,1,0,1,0,0,1,0,1,1. Each bit is held 4 clks. One frame_done pulse. tx_state returns to 1.
- 8E1, write 0x03 → data bits 1,1,0,0,0,0,0,0, then parity 0, then stop 1. With 8O1 and the same data, the parity bit is 1.
- 7O2, write 0x7F → 0, seven 1s, parity 0, stop 1,1. Frame is 11 ticks.
- Back-to-back 8N1: write 0x55 then 0xAA as soon as tx_ready rises → the second start bit lands on the first frame's end tick with no idle bit. tx_state stays 0 across both frames; frame_done pulses twice.
- Overrun: with hold full, pulse wr_en with 0xFF → ignored. The held byte is transmitted unchanged and tx_ready stays 0 until the hold is consumed.
- Assert rst_n=0 during data bit 3 → tx=1 immediately, tx_ready=1, tx_state=1. After release, a new write of 0x0F transmits a clean frame.
